mips_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the MIPS decoder. It holds the PC and requests words from instruction memory over a ready handshake. It presents the fetched instruction, including its opcode/funct fields, to the decoder. It computes the next PC from the decoder's control_type, the zero flag result already folded into control_type, and the jr register value. The decoder's except output halts fetch.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_next_pc.sv | 42 ++++
 rtl/mips_fetch_unit.sv | 138 +++++++++++++
 tb/tb_mips_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS fetch stage: control_type
//               encodings, fetch state enum and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [1:0] CT_FALLTHRU = 2'b00;
  localparam logic [1:0] CT_BRANCH   = 2'b01;
  localparam logic [1:0] CT_JUMP     = 2'b10;
  localparam logic [1:0] CT_JR       = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : mips_next_pc
// Description : Combinational next-PC target computation for the fetch stage
//               (fallthrough, PC-relative branch, region jump, jump register).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [1:0]  control_type,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_branch_off;
  logic        unused_opcode_bits;

  assign w_pc4        = pc + 32'd4;
  assign w_branch_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  // Opcode bits play no part in the target address.
  assign unused_opcode_bits = ^inst[31:26];

  // Select the target; jr always lands on a word boundary (misaligned
  // values are either trapped upstream or have their low bits dropped).
  always_comb begin
    next_pc = w_pc4;
    case (control_type)
      CT_FALLTHRU: next_pc = w_pc4;
      CT_BRANCH:   next_pc = w_pc4 + w_branch_off;
      CT_JUMP:     next_pc = {w_pc4[31:28], inst[25:0], 2'b00};
      CT_JR:       next_pc = rs_data & 32'hFFFF_FFFC;
      default:     next_pc = w_pc4;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_unit
// Description : MIPS instruction-fetch stage. Holds the PC, requests words
//               from instruction memory with a ready handshake, presents the
//               held instruction to the decoder and advances the PC on retire.
//               Optional macro MIPS_FETCH_ALIGN_CHECK_EN traps misaligned jr
//               targets with a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              retire,
  input  logic [1:0]        control_type,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              except,
  output logic              halted,
  output logic              fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  w_next_pc;
  logic         w_capture;
  logic         w_pc_load;
  logic         w_misaligned_jr;

  mips_next_pc u_next_pc (
    .pc           (r_pc),
    .inst         (r_inst),
    .control_type (control_type),
    .rs_data      (rs_data),
    .next_pc      (w_next_pc)
  );

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_misaligned_jr = (control_type == CT_JR) && (rs_data[1:0] != 2'b00);

  // Sticky fault set when a misaligned jr retires; cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset)
      r_fault <= 1'b0;
    else if ((r_state == ST_ISSUE) && !except && retire && w_misaligned_jr)
      r_fault <= 1'b1;
  end

  assign fault = r_fault;
`else
  assign w_misaligned_jr = 1'b0;
  assign fault           = 1'b0;
`endif

  // Fetch state register.
  always_ff @(posedge clock) begin
    if (reset)
      r_state <= ST_FETCH;
    else
      r_state <= w_state_next;
  end

  // PC and instruction holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_inst <= 32'd0;
    end else begin
      if (w_capture)
        r_inst <= imem_rdata;
      if (w_pc_load)
        r_pc <= w_next_pc;
    end
  end

  // Next-state and handshake outputs; except outranks retire in ISSUE.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    inst_valid   = 1'b0;
    halted       = 1'b0;
    w_capture    = 1'b0;
    w_pc_load    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_capture    = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        inst_valid = 1'b1;
        if (except) begin
          w_state_next = ST_HALT;
        end else if (retire) begin
          if (w_misaligned_jr) begin
            w_state_next = ST_HALT;
          end else begin
            w_pc_load    = 1'b1;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_next = ST_HALT;
      end
    endcase
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign opcode    = r_inst[31:26];
  assign funct     = r_inst[5:0];

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_unit
// Description : Self-checking bench for mips_fetch_unit: directed vector
//               table, hand-written multi-cycle sequences and randomized
//               transactions checked against a behavioural next-PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic        inst_valid;
  logic        retire = 1'b0;
  logic [1:0]  control_type = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic        except = 1'b0;
  logic        halted;
  logic        fault;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] model_pc;
  logic [31:0] model_inst;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic [1:0]  ct;
    logic [31:0] rs;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tv[7];

  mips_fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .opcode       (opcode),
    .funct        (funct),
    .pc           (pc),
    .inst_valid   (inst_valid),
    .retire       (retire),
    .control_type (control_type),
    .rs_data      (rs_data),
    .except       (except),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  // Safety net: the stimulus is fixed-length, but never let a run hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Next PC derived directly from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [1:0] ct, input logic [31:0] rs);
    logic [31:0] pc4;
    logic [31:0] off;
    logic [15:0] imm;
    pc4 = p + 32'd4;
    imm = w[15:0];
    off = 32'($signed(imm) * 4);
    case (ct)
      2'd0:    return pc4;
      2'd1:    return pc4 + off;
      2'd2:    return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
      default: return rs - (rs % 4);
    endcase
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    imem_ready   = 1'b0;
    retire       = 1'b0;
    except       = 1'b0;
    control_type = 2'b00;
    rs_data      = 32'd0;
    imem_rdata   = 32'd0;
    tick();
    tick();
    reset      = 1'b0;
    model_pc   = RST_PC;
    model_inst = 32'd0;
  endtask

  task automatic check_reset_state();
    chk("rst_req",   32'(imem_req), 32'd1);
    chk("rst_addr",  imem_addr, RST_PC);
    chk("rst_inst",  inst, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_halt",  32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
  endtask

  // Serve one fetch after 'waits' not-ready cycles; checks the held issue view.
  task automatic fetch_word(input logic [31:0] word, input int waits);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      chk("wait_req",   32'(imem_req), 32'd1);
      chk("wait_addr",  imem_addr, model_pc);
      chk("wait_valid", 32'(inst_valid), 32'd0);
      chk("wait_inst",  inst, model_inst);
      tick();
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    chk("req_addr", imem_addr, model_pc);
    chk("req_req",  32'(imem_req), 32'd1);
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    model_inst = word;
    chk("iss_valid",  32'(inst_valid), 32'd1);
    chk("iss_inst",   inst, word);
    chk("iss_pc",     pc, model_pc);
    chk("iss_opcode", 32'(opcode), 32'(word >> 26));
    chk("iss_funct",  32'(funct), word & 32'h3F);
    chk("iss_req",    32'(imem_req), 32'd0);
  endtask

  // Hold for 'hold' cycles with noisy ct/rs, then retire and check next fetch.
  task automatic retire_insn(input logic [1:0] ct, input logic [31:0] rs,
                             input int hold, input logic [31:0] exp_next);
    for (int h = 0; h < hold; h++) begin
      retire       = 1'b0;
      control_type = 2'($urandom);
      rs_data      = $urandom;
      tick();
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst",  inst, model_inst);
      chk("hold_pc",    pc, model_pc);
      chk("hold_req",   32'(imem_req), 32'd0);
    end
    retire       = 1'b1;
    control_type = ct;
    rs_data      = rs;
    tick();
    retire       = 1'b0;
    model_pc     = exp_next;
    chk("next_req",  32'(imem_req), 32'd1);
    chk("next_addr", imem_addr, exp_next);
    chk("next_valid", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] rs;
    logic [1:0]  ct;

    tv[0] = '{32'h0040_0000, 32'h2108_0001, 2'b00, 32'h0,         32'h0040_0004};
    tv[1] = '{32'h0040_0010, 32'h1000_FFFC, 2'b01, 32'h0,         32'h0040_0004};
    tv[2] = '{32'h0040_0010, 32'h1000_0003, 2'b01, 32'h0,         32'h0040_0020};
    tv[3] = '{32'h0040_0000, 32'h0810_0008, 2'b10, 32'h0,         32'h0040_0020};
    tv[4] = '{32'h0040_0000, 32'h0000_0008, 2'b11, 32'h0040_1000, 32'h0040_1000};
    tv[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 32'h0,         32'h0000_0000};
    tv[6] = '{32'h3FFF_FFFC, 32'h0800_0000, 2'b10, 32'h0,         32'h4000_0000};

    @(negedge clock);

    // Reset state and the first directed transaction.
    do_reset();
    check_reset_state();

    // Directed table: steer PC to start_pc with a jr, then apply the vector.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      fetch_word(32'h0000_0008, 0);
      retire_insn(2'b11, tv[i].start_pc, 0, tv[i].start_pc);
      fetch_word(tv[i].word, 0);
      retire_insn(tv[i].ct, tv[i].rs, 0, tv[i].exp_next);
    end

    // Wait states on memory and a long hold before retire.
    do_reset();
    fetch_word(32'h2108_0001, 3);
    retire_insn(2'b00, 32'h0, 4, 32'h0040_0004);

    // Except together with retire halts fetch; only reset recovers.
    do_reset();
    fetch_word(32'hFC00_003F, 0);
    except       = 1'b1;
    retire       = 1'b1;
    control_type = 2'b00;
    tick();
    except     = 1'b0;
    retire     = 1'b0;
    imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("exc_halted", 32'(halted), 32'd1);
      chk("exc_valid",  32'(inst_valid), 32'd0);
      chk("exc_req",    32'(imem_req), 32'd0);
      chk("exc_pc",     pc, RST_PC);
      tick();
    end
    do_reset();
    check_reset_state();

    // Reset while a request is outstanding at a non-reset address.
    fetch_word(32'h2108_0001, 0);
    retire_insn(2'b00, 32'h0, 0, 32'h0040_0004);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_req",  32'(imem_req), 32'd1);
    chk("midrst_addr", imem_addr, RST_PC);

    // Misaligned jr target.
    do_reset();
    fetch_word(32'h0000_0008, 0);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    retire       = 1'b1;
    control_type = 2'b11;
    rs_data      = 32'h0040_1002;
    tick();
    retire     = 1'b0;
    imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("mis_fault",  32'(fault), 32'd1);
      chk("mis_halted", 32'(halted), 32'd1);
      chk("mis_req",    32'(imem_req), 32'd0);
      chk("mis_pc",     pc, RST_PC);
      tick();
    end
    imem_ready = 1'b0;
`else
    retire_insn(2'b11, 32'h0040_1002, 0, 32'h0040_1000);
    chk("mis_fault", 32'(fault), 32'd0);
`endif

    // Randomized transactions against the behavioural model.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      word = $urandom;
      fetch_word(word, int'($urandom_range(0, 3)));
      ct = 2'($urandom_range(0, 3));
      rs = $urandom;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
      rs = rs & 32'hFFFF_FFFC;
`endif
      retire_insn(ct, rs, int'($urandom_range(0, 2)), ref_next(model_pc, word, ct, rs));
      chk("rnd_fault", 32'(fault), 32'd0);
      chk("rnd_halt",  32'(halted), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
